// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: performs one wide add or subtract per request by
// stepping a shared external 4-bit adder across the operands, least
// significant nibble first, one nibble per clock. The carry between nibbles
// is held in a register. A start/busy/done handshake, registered result,
// carry-out and signed overflow are provided to the requester.

module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_co
);

    localparam int W  = 4 * NIBBLES;
    localparam int PW = $clog2(NIBBLES);
    localparam logic [PW-1:0] PTR_LAST = PW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [W-1:0]    opa_r;
    logic [W-1:0]    opb_r;     // holds ~b for a subtract, so RUN only ever adds
    logic [W-1:0]    sum_r;
    logic [PW-1:0]   ptr_r;
    logic            carry_r;   // seeded with sub, giving the +1 of two's complement
    logic            busy_r;
    logic            done_r;
    logic            cout_r;
    logic            ovf_r;
    logic [PW+1:0]   base_s;    // bit offset of the current nibble

    assign base_s = {ptr_r, 2'b00};

    // Sequencer: accept a request, walk the nibbles, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            opa_r   <= '0;
            opb_r   <= '0;
            sum_r   <= '0;
            ptr_r   <= '0;
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // The subtract is folded into the latched operand and
                        // the initial carry, so no separate mode flag is kept.
                        opa_r   <= a;
                        opb_r   <= sub ? ~b : b;
                        carry_r <= sub;
                        ptr_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_r[base_s +: 4] <= add_s;
                    carry_r            <= add_co;
                    if (ptr_r == PTR_LAST) begin
                        // Top nibble: its sum bit 3 is the result sign bit.
                        cout_r  <= add_co;
                        ovf_r   <= (opa_r[W-1] == opb_r[W-1]) &&
                                   (add_s[3] != opa_r[W-1]);
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        ptr_r   <= ptr_r + 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the external adder with the current nibble only while running.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_r == ST_RUN) begin
            add_a   = opa_r[base_s +: 4];
            add_b   = opb_r[base_s +: 4];
            add_cin = carry_r;
        end else begin
            add_a   = 4'h0;
            add_b   = 4'h0;
            add_cin = 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench for nibble_add_sequencer (NIBBLES=4) with a behavioural
// 4-bit adder on the add_* ports and an arithmetic reference model.

module tb_nibble_add_sequencer;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf, add_cin, add_co;
    logic [W-1:0] sum;
    logic [3:0]   add_a, add_b, add_s;

    int errs = 0;
    int checks = 0;

    nibble_add_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_co(add_co)
    );

    // External 4-bit adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint unsigned ux, uy, ur;
        longint sx, sy, sr, smax, smin;
        logic c, o;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (s) begin
            ur = ux - uy; c = (ux >= uy); sr = sx - sy;
        end else begin
            ur = ux + uy; c = ((ur >> W) != 0); sr = sx + sy;
        end
        o = (sr > smax) || (sr < smin);
        return {o, c, ur[W-1:0]};
    endfunction

    // Carry entering nibble i of x +/- y.
    function automatic logic cin_at(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int i);
        longint unsigned ux, uy, mask, t;
        if (i == 0) return s;
        ux = x;
        uy = s ? {48'h0, ~y} : {48'h0, y};
        mask = (64'd1 << (4 * i)) - 64'd1;
        t = (ux & mask) + (uy & mask) + {63'd0, s};
        return t[4 * i];
    endfunction

    // Model state: cycles left in the current operation and its operands.
    logic [W+1:0] expq[$];
    int           cnt = 0;
    logic [W-1:0] cur_a = '0, cur_b = '0;
    logic         cur_s = 1'b0;
    logic [W+1:0] held = '0;

    // Acceptance model: a request is taken only when the previous one is over.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
            expq.delete();
        end else if (cnt == 0) begin
            if (start) begin
                expq.push_back(ref_op(a, b, sub));
                cur_a <= a; cur_b <= b; cur_s <= sub;
                cnt <= N + 1;
            end
        end else begin
            cnt <= cnt - 1;
        end
    end

    // Monitor: compare every cycle, pop the scoreboard on done.
    always @(negedge clk) begin
        logic [W+1:0] e;
        logic [W-1:0] eb;
        int idx;
        if (!rst_n) begin
            held = '0;
            chk("reset_outputs", {busy, done, cout, ovf, sum}, 64'd0);
            chk("reset_adder", {add_a, add_b, add_cin}, 64'd0);
        end else begin
            chk("busy", busy, (cnt != 0));
            chk("done", done, (cnt == 1));
            if (cnt >= 2) begin
                idx = N + 1 - cnt;
                eb = cur_s ? ~cur_b : cur_b;
                chk("add_a", add_a, cur_a[4*idx +: 4]);
                chk("add_b", add_b, eb[4*idx +: 4]);
                chk("add_cin", add_cin, cin_at(cur_a, cur_b, cur_s, idx));
                chk("flags_hold_run", {cout, ovf}, {held[W], held[W+1]});
            end else begin
                chk("adder_idle", {add_a, add_b, add_cin}, 64'd0);
            end
            if (cnt == 0)
                chk("result_hold", {ovf, cout, sum}, held);
            if (done) begin
                if (expq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("result", {ovf, cout, sum}, e);
                    held = e;
                end
            end
        end
    end

    task automatic op_chk(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(negedge clk);
        chk("directed_sum", sum, es);
        chk("directed_cout", cout, ec);
        chk("directed_ovf", ovf, eo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op_chk(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        op_chk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_chk(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op_chk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op_chk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // start held high with operands toggling every cycle
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        // random requests with random gaps
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        repeat (N + 3) @(negedge clk);

        // asynchronous reset in the middle of RUN (ptr=2)
        a = 16'hABCD; b = 16'h1357; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_now", {busy, done, cout, ovf, sum}, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        op_chk(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", expq.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
- Controller that sequences one external 4-bit ripple-carry adder (combinational: A, B, Ci in; S, Co out) to perform one wide add or subtract per request.
- Operand width is 4*NIBBLES bits, processed least-significant nibble first, one nibble per clock, with the carry chained through an internal register.
- Sits between a requesting unit and the shared 4-bit adder instance.
- Provides a start/busy/done handshake, registered results, carry-out and signed overflow.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A-B; latched with the operands
- a  input  W  operand A, unsigned or two's complement
- b  input  W  operand B
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; results valid from this cycle
- sum  output  W  result, held until the next accepted start
- cout  output  1  final carry (subtract: 1 = no borrow)
- ovf  output  1  two's-complement overflow of the W-bit result
- add_a  output  4  to adder A input
- add_b  output  4  to adder B input
- add_cin  output  1  to adder carry-in
- add_s  input  4  from adder sum
- add_co  input  1  from adder carry-out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, cout, ovf, sum, nibble pointer, carry register and operand registers all 0. This holds at any point, including mid-operation. Operation resumes on the first rising edge after rst_n deasserts.
- States are IDLE, RUN and DONE.
- IDLE: when start=1 at edge k:
  - latch a into opa.
  - latch b into opb. If sub=1, latch ~b instead.
  - latch sub.
  - set ptr=0, carry=sub, state=RUN.
  - Otherwise remain in IDLE.
- RUN: add_a = opa[4*ptr+3:4*ptr], add_b = opb[4*ptr+3:4*ptr], add_cin = carry, all driven combinationally from registers. On each edge:
  - sum nibble[ptr] <= add_s.
  - carry <= add_co.
  - ptr <= ptr+1.
- RUN exit: at the edge where ptr=NIBBLES-1:
  - cout <= add_co.
  - ovf <= (opa[W-1] == opb[W-1]) && (add_s[3] != opa[W-1]).
  - state <= DONE.
  - There is no wrap-around; ptr never exceeds NIBBLES-1.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge. start is ignored in DONE.
- Latency: start sampled at edge k; done high in the cycle after edge k+NIBBLES; next start is accepted at edge k+NIBBLES+2 at the earliest.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- start, a, b and sub are ignored while busy=1. Changes to them mid-operation do not affect the result.
- sum, cout and ovf are updated only by an operation in progress:
  - sum nibbles change during RUN; the full word is valid from done.
  - All three then hold until the next accepted start.
- No internal arithmetic beyond the overflow compare; all addition goes through the external adder.

Test Plan (NIBBLES=4; test bench instantiates the 4-bit adder on the add_* ports):
- a=16'h1234, b=16'h0FFF, sub=0, start pulsed at edge 0 -> done high after edge 4 only; sum=16'h2233, cout=0, ovf=0; busy high from edge 0 through DONE.
- a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, cout=1, ovf=0; observe add_cin=1 on nibbles 1..3.
- a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0, ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1, cout=0.
- start held high continuously; a, b and sub toggled every cycle during RUN -> operations accepted only in IDLE, one every NIBBLES+2 cycles; each result matches the operands sampled at acceptance.
- rst_n pulled low for 1 cycle during RUN at ptr=2 -> busy, done, sum, cout and ovf are 0 immediately, without waiting for a clock edge. After release, a fresh 16'h0001+16'h0001 gives sum=16'h0002 with the normal latency.
